// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op encodings, FSM states and divide special-case constants
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_FIX     = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_QUOT = '1;
  localparam logic [XLEN-1:0] OVF_QUOT      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] OVF_REM       = '0;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn & v[XLEN-1]) ? -v : v;
  endfunction

  // Result for the two cases the restoring core cannot sign-correct on its own
  function automatic logic [XLEN-1:0] div_special(input logic is_rem, input logic div0,
                                                  input logic [XLEN-1:0] dividend);
    if (div0) return is_rem ? dividend : DIV_ZERO_QUOT;
    return is_rem ? OVF_REM : OVF_QUOT;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// rtl/muldiv_unit_div_iter.sv - radix-2 restoring divider core on unsigned magnitudes
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int ITERS = XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_last,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(ITERS);

  logic [CW-1:0]   r_cnt;
  logic            r_run;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // Dividend bits shift out of r_quo into the partial remainder while quotient bits shift in
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign o_last  = r_run & (r_cnt == CW'(ITERS-1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  always_ff @(posedge i_clk) begin
    if (i_reset | i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
    end else if (r_run) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
      if (o_last) begin
        r_cnt <= '0;
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M execute unit: 1-cycle multiply, iterative divide with pipeline stall
// Optional MULDIV_EARLY_OUT_EN: trivial divides (by zero, overflow, |a|<|b|) finish in one cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_ITERS = XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic [XLEN-1:0] o_result,
  output logic            o_valid
);

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic            r_ovf;
  logic [XLEN-1:0] r_dividend;

  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_a64, w_b64, w_prod;
  logic [XLEN-1:0]   w_mul_result;
  logic              w_signed, w_is_rem, w_div0, w_ovf, w_early;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_div_start, w_div_last;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_result;

  // Sign-extending to the full product width keeps the low 2*XLEN bits exact for every signedness mix
  assign w_sa   = (i_funct3 == F3_MULH) | (i_funct3 == F3_MULHSU);
  assign w_sb   = (i_funct3 == F3_MULH);
  assign w_a64  = {{XLEN{w_sa & i_data1[XLEN-1]}}, i_data1};
  assign w_b64  = {{XLEN{w_sb & i_data2[XLEN-1]}}, i_data2};
  assign w_prod = w_a64 * w_b64;
  assign w_mul_result = (i_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_signed = (i_funct3 == F3_DIV) | (i_funct3 == F3_REM);
  assign w_is_rem = (i_funct3 == F3_REM) | (i_funct3 == F3_REMU);
  assign w_abs_a  = abs_val(i_data1, w_signed);
  assign w_abs_b  = abs_val(i_data2, w_signed);
  assign w_div0   = (i_data2 == '0);
  assign w_ovf    = w_signed & (i_data1 == OVF_QUOT) & (i_data2 == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] w_early_result;
  assign w_early = w_div0 | w_ovf | (w_abs_a < w_abs_b);
  assign w_early_result = (w_div0 | w_ovf) ? div_special(w_is_rem, w_div0, i_data1)
                                           : (w_is_rem ? i_data1 : '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_div_start = (r_state == ST_IDLE) & i_start & i_funct3[2] & ~i_flush & ~w_early;

  muldiv_unit_div_iter #(.ITERS(DIV_ITERS)) u_div_iter (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_flush),
    .i_start     (w_div_start),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_last      (w_div_last),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_fix_result = (r_div0 | r_ovf) ? div_special(r_is_rem, r_div0, r_dividend)
                      : r_is_rem ? (r_neg_r ? -w_rem : w_rem)
                                 : (r_neg_q ? -w_quo : w_quo);

  assign o_stall  = ((r_state == ST_IDLE) & i_start & i_funct3[2]) |
                    (r_state == ST_DIV_RUN) | (r_state == ST_FIX);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_result = r_result;
  assign o_valid  = r_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_dividend <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (!i_funct3[2]) begin
                r_result <= w_mul_result;
                r_valid  <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
              end else if (w_early) begin
                r_result <= w_early_result;
                r_valid  <= 1'b1;
`endif
              end else begin
                r_is_rem   <= w_is_rem;
                r_neg_q    <= w_signed & (i_data1[XLEN-1] ^ i_data2[XLEN-1]);
                r_neg_r    <= w_signed & i_data1[XLEN-1];
                r_div0     <= w_div0;
                r_ovf      <= w_ovf;
                r_dividend <= i_data1;
                r_state    <= ST_DIV_RUN;
              end
            end
          end
          ST_DIV_RUN: if (w_div_last) r_state <= ST_FIX;
          ST_FIX: begin
            r_result <= w_fix_result;
            r_valid  <= 1'b1;
            r_state  <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench with an arithmetic reference model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_data1, i_data2;
  logic        o_stall, o_busy, o_valid;
  logic [31:0] o_result;

  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_funct3 (i_funct3),
    .i_data1  (i_data1),
    .i_data2  (i_data2),
    .i_flush  (i_flush),
    .o_stall  (o_stall),
    .o_busy   (o_busy),
    .o_result (o_result),
    .o_valid  (o_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] abs_of(input logic [31:0] v, input bit sgn);
    return (sgn && v[31]) ? (32'h0 - v) : v;
  endfunction

  // Reference: RISC-V M semantics straight from integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    if (!f3[2]) return 1;
    sgn = !f3[0];
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
        abs_of(a, sgn) < abs_of(b, sgn)) return 1;
`else
    if (sgn && abs_of(a, sgn) < abs_of(b, sgn)) return 34;
`endif
    return 34;
  endfunction

  // Every VALID pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_valid: got result %h, expected no VALID", o_result);
      end else begin
        check("result", o_result, exp_q.pop_front());
        check("busy_at_valid", {31'h0, o_busy}, 32'h0);
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat, stalls, elat;
    bit seen;
    last_exp = model(f3, a, b);
    exp_q.push_back(last_exp);
    elat = exp_latency(f3, a, b);
    i_start = 1'b1; i_funct3 = f3; i_data1 = a; i_data2 = b;
    @(negedge clk);
    stalls = o_stall ? 1 : 0;
    @(posedge clk); #1;
    i_start = 1'b0; i_data1 = $urandom; i_data2 = $urandom;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (o_stall) stalls++;
      if (o_valid) seen = 1;
    end
    check($sformatf("latency f3=%0d %h/%h", f3, a, b), lat, elat);
    check($sformatf("stall_cycles f3=%0d %h/%h", f3, a, b), stalls, f3[2] ? elat : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
    i_funct3 = 3'd0; i_data1 = 32'h0; i_data2 = 32'h0;

    check("pin_mul",    model(3'd0, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFA);
    check("pin_mulh",   model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_mulhu",  model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("pin_div",    model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu",   model(3'd5, 32'd1000, 32'd7), 32'd142);

    repeat (2) @(posedge clk);
    #1;
    check("reset_result", o_result, 32'h0);
    check("reset_valid", {31'h0, o_valid}, 32'h0);
    check("reset_busy", {31'h0, o_busy}, 32'h0);
    check("reset_stall", {31'h0, o_stall}, 32'h0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd0);
    run_op(3'd7, 32'd100, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd5, 32'd5, 32'd9);
    run_op(3'd4, 32'd64, 32'd0);
    run_op(3'd6, 32'hFFFF_FFF0, 32'd0);

    // Flush mid-divide: no VALID, result held, unit idle after the flush edge
    i_start = 1'b1; i_funct3 = 3'd4; i_data1 = 32'd1000; i_data2 = 32'd7;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_busy", {31'h0, o_busy}, 32'h0);
    check("flush_stall", {31'h0, o_stall}, 32'h0);
    check("flush_result_held", o_result, last_exp);
    repeat (40) @(posedge clk);
    #1;

    // Flush together with START in IDLE discards the op
    i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_data1 = 32'd3; i_data2 = 32'd5;
    @(posedge clk); #1;
    i_start = 1'b0; i_flush = 1'b0;
    check("flush_start_valid", {31'h0, o_valid}, 32'h0);
    check("flush_start_result", o_result, last_exp);

    run_op(3'd5, 32'd1000, 32'd7);

    // Reset mid-divide
    i_start = 1'b1; i_funct3 = 3'd5; i_data1 = 32'd1000; i_data2 = 32'd7;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_result", o_result, 32'h0);
    check("midreset_valid", {31'h0, o_valid}, 32'h0);
    check("midreset_stall", {31'h0, o_stall}, 32'h0);
    check("midreset_busy", {31'h0, o_busy}, 32'h0);
    i_reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    run_op(3'd6, 32'd1000, 32'd7);

    check("outstanding_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
